// File: rtl/rst_seq_pkg.sv
// Shared types and default timing for the reset sequencer.
// Imported by rst_seq and by anything that integrates it.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        STEP,
        DONE
    } rst_seq_state_e;

    localparam int RST_SEQ_N_DOM    = 4;
    localparam int RST_SEQ_HOLD_CYC = 16;
    localparam int RST_SEQ_STEP_CYC = 8;

endpackage

// File: rtl/rst_seq.sv
// Ordered release of N_DOM domain resets after a hold period, with a
// soft-reset request/ack handshake that replays the whole sequence.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_DOM    = RST_SEQ_N_DOM,
    parameter int HOLD_CYC = RST_SEQ_HOLD_CYC,
    parameter int STEP_CYC = RST_SEQ_STEP_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst_req,
    output logic             soft_rst_ack,
    output logic [N_DOM-1:0] dom_rst,
    output logic             seq_done,
    output logic             busy
);

    localparam int CNT_MAX = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);

    rst_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_DOM-1:0] dom_q, dom_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             soft_q, soft_d;
    logic             last_rel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dom_d    = dom_q;
        done_d   = done_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        soft_d   = soft_q;
        last_rel = 1'b0;

        unique case (state_q)
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    dom_d[0] = 1'b0;
                    state_d  = STEP;
                    last_rel = (N_DOM == 1);
                end
            end
            STEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int k = 1; k < N_DOM; k++) begin
                        if (k == int'(idx_q) + 1) dom_d[k] = 1'b0;
                    end
                    last_rel = (int'(idx_q) == N_DOM - 2);
                end
            end
            DONE: begin
                // The ack cycle itself never accepts, so a held req
                // replays only if it is still high one cycle later.
                if (soft_rst_req && !ack_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '1;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    soft_d  = 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase

        if (last_rel) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ack_d   = soft_q;
            soft_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            soft_q  <= soft_d;
        end
    end

    assign dom_rst      = dom_q;
    assign seq_done     = done_q;
    assign busy         = busy_q;
    assign soft_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: three parameter sets driven together, checked
// every cycle against a cycle-offset model plus literal timing points.
module tb_rst_seq;
    import rst_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [3:0] dom0;
    logic [0:0] dom1;
    logic [2:0] dom2;
    logic [2:0] done_v, busy_v, ack_v;
    logic [3:0] dom_a [3];

    rst_seq #(.N_DOM(4), .HOLD_CYC(RST_SEQ_HOLD_CYC),
              .STEP_CYC(RST_SEQ_STEP_CYC)) u0 (
        .clk(clk), .rst(rst), .soft_rst_req(req),
        .soft_rst_ack(ack_v[0]), .dom_rst(dom0),
        .seq_done(done_v[0]), .busy(busy_v[0]));

    rst_seq #(.N_DOM(1), .HOLD_CYC(1), .STEP_CYC(1)) u1 (
        .clk(clk), .rst(rst), .soft_rst_req(req),
        .soft_rst_ack(ack_v[1]), .dom_rst(dom1),
        .seq_done(done_v[1]), .busy(busy_v[1]));

    rst_seq #(.N_DOM(3), .HOLD_CYC(1), .STEP_CYC(1)) u2 (
        .clk(clk), .rst(rst), .soft_rst_req(req),
        .soft_rst_ack(ack_v[2]), .dom_rst(dom2),
        .seq_done(done_v[2]), .busy(busy_v[2]));

    assign dom_a[0] = dom0;
    assign dom_a[1] = {3'b000, dom1};
    assign dom_a[2] = {1'b0, dom2};

    int NP [3] = '{4, 1, 3};
    int HP [3] = '{16, 1, 1};
    int SP [3] = '{8, 1, 1};

    // Model: each instance is described only by the cycle offset since
    // its sequence started and whether a soft request started it.
    int mc    [3] = '{0, 0, 0};
    bit msoft [3] = '{0, 0, 0};
    bit mvalid = 1'b0;
    int tcyc   = 0;
    int n_cmp  = 0;
    int n_err  = 0;

    function automatic int fin_cyc(int i);
        return HP[i] + (NP[i] - 1) * SP[i];
    endfunction

    function automatic logic [3:0] exp_dom(int i, int cc);
        logic [3:0] d = 4'b0000;
        for (int k = 0; k < NP[i]; k++) d[k] = (cc < HP[i] + k * SP[i]);
        return d;
    endfunction

    function automatic bit exp_ack(int i);
        return msoft[i] && (mc[i] == fin_cyc(i));
    endfunction

    always @(posedge clk) begin
        if (rst) mvalid <= 1'b1;
        tcyc <= rst ? 0 : tcyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mc[i]    <= 0;
                msoft[i] <= 1'b0;
            end else if (req && mc[i] >= fin_cyc(i) && !exp_ack(i)) begin
                mc[i]    <= 0;
                msoft[i] <= 1'b1;
            end else if (mc[i] < 1000000) begin
                mc[i] <= mc[i] + 1;
            end
        end
    end

    task automatic cmp_model();
        logic [6:0] act, exp;
        bit dn;
        if (!mvalid) return;
        for (int i = 0; i < 3; i++) begin
            dn  = (mc[i] >= fin_cyc(i));
            exp = {exp_dom(i, mc[i]), dn, !dn, exp_ack(i)};
            act = {dom_a[i], done_v[i], busy_v[i], ack_v[i]};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL model inst%0d t=%0d got dom/done/busy/ack=%b want %b",
                         i, tcyc, act, exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got %h want %h", nm, tcyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (tcyc != n) begin
            tick();
            g++;
            if (g > 2000) begin
                n_err++;
                $display("FAIL timeout waiting cycle %0d got %0d", n, tcyc);
                return;
            end
        end
    endtask

    task automatic power_up();
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
    endtask

    initial begin
        power_up();
        chk("u1_dom_c0", 32'(dom1), 32'h1);
        wait_cyc(1);
        chk("u1_dom_c1", 32'(dom1), 32'h0);
        chk("u1_done_c1", 32'(done_v[1]), 32'h1);
        chk("u2_dom_c1", 32'(dom2), 32'h6);
        wait_cyc(2);
        chk("u2_dom_c2", 32'(dom2), 32'h4);
        wait_cyc(3);
        chk("u2_dom_c3", 32'(dom2), 32'h0);
        wait_cyc(15);
        chk("dom_c15", 32'(dom0), 32'hF);
        wait_cyc(16);
        chk("dom_c16", 32'(dom0), 32'hE);
        wait_cyc(20);
        req = 1'b1;
        wait_cyc(21);
        req = 1'b0;
        wait_cyc(24);
        chk("dom_c24", 32'(dom0), 32'hC);
        wait_cyc(32);
        chk("dom_c32", 32'(dom0), 32'h8);
        wait_cyc(39);
        chk("busy_c39", 32'(busy_v[0]), 32'h1);
        wait_cyc(40);
        chk("dom_c40", 32'(dom0), 32'h0);
        chk("done_c40", 32'(done_v[0]), 32'h1);
        chk("busy_c40", 32'(busy_v[0]), 32'h0);

        wait_cyc(50);
        req = 1'b1;
        wait_cyc(51);
        chk("soft_dom_c51", 32'(dom0), 32'hF);
        chk("soft_busy_c51", 32'(busy_v[0]), 32'h1);
        wait_cyc(66);
        chk("soft_dom_c66", 32'(dom0), 32'hF);
        wait_cyc(67);
        chk("soft_dom_c67", 32'(dom0), 32'hE);
        wait_cyc(90);
        chk("ack_c90", 32'(ack_v[0]), 32'h0);
        wait_cyc(91);
        chk("ack_c91", 32'(ack_v[0]), 32'h1);
        req = 1'b0;
        wait_cyc(92);
        chk("ack_c92", 32'(ack_v[0]), 32'h0);
        wait_cyc(120);
        chk("idle_dom_c120", 32'(dom0), 32'h0);

        wait_cyc(130);
        req = 1'b1;
        wait_cyc(171);
        chk("ack_c171", 32'(ack_v[0]), 32'h1);
        wait_cyc(172);
        chk("dom_c172", 32'(dom0), 32'h0);
        wait_cyc(173);
        chk("replay_dom_c173", 32'(dom0), 32'hF);
        wait_cyc(213);
        chk("ack_c213", 32'(ack_v[0]), 32'h1);
        req = 1'b0;
        wait_cyc(260);

        power_up();
        wait_cyc(28);
        chk("mid_dom_c28", 32'(dom0), 32'hC);
        rst = 1'b1;
        tick();
        chk("mid_rst_dom", 32'(dom0), 32'hF);
        tick();
        rst = 1'b0;
        wait_cyc(15);
        chk("rerun_dom_c15", 32'(dom0), 32'hF);
        wait_cyc(16);
        chk("rerun_dom_c16", 32'(dom0), 32'hE);
        wait_cyc(40);
        chk("rerun_dom_c40", 32'(dom0), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
